// File: rtl/cpu_branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_branch_predictor_pkg
// Shared constants for the fetch-stage branch predictor: the 2-bit
// saturating counter encodings, the default table size and the saturation
// ceiling of the statistics counters.
// ---------------------------------------------------------------------------
package cpu_branch_predictor_pkg;

  // Two-bit counter states; the MSB alone is the taken/not-taken prediction
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } sat_cnt_e;

  localparam int          DEFAULT_ENTRIES = 16;
  localparam logic [31:0] STAT_MAX        = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// cpu_sat_counter2
// Next-state function of a 2-bit saturating counter.
// Ports:
//   cnt  - current counter value
//   inc  - 1: count up (stick at strongly taken), 0: count down
//          (stick at strongly not-taken)
//   next - counter value after the step
// ---------------------------------------------------------------------------
module cpu_sat_counter2
  import cpu_branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] next
);

  // Step up or down by one, clamping at the two end states
  always_comb begin
    next = cnt;
    if (inc) begin
      if (cnt != CNT_ST) next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/cpu_branch_predictor.sv
// ---------------------------------------------------------------------------
// cpu_branch_predictor
// Direct-mapped branch predictor with a branch target per entry. Fetch looks
// up combinationally; execute trains one entry per cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   f_pc              - fetch PC to predict
//   f_pred_taken      - predicted taken for f_pc
//   f_pred_target     - predicted target (meaningful only when taken)
//   e_valid           - a resolved conditional branch is in execute
//   e_pc, e_taken,
//   e_target          - its PC, actual outcome and actual target
//   e_pred_taken      - the prediction that travelled with it
//   e_mispredict      - outcome differs from the carried prediction
//   mispredict_count,
//   branch_count      - saturating statistics
// ---------------------------------------------------------------------------
module cpu_branch_predictor
  import cpu_branch_predictor_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            e_valid,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_taken,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  output logic            e_mispredict,
  output logic [31:0]     mispredict_count,
  output logic [31:0]     branch_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [1:0]      r_cnt    [ENTRIES];
  logic [31:0]     r_branchCount;
  logic [31:0]     r_mispredictCount;

  logic [IDX-1:0]  w_fIdx;
  logic [TAGW-1:0] w_fTag;
  logic [IDX-1:0]  w_eIdx;
  logic [TAGW-1:0] w_eTag;
  logic            w_eHit;
  logic [1:0]      w_cntNext;
  logic            w_unused;

  // Instructions are word aligned, so the two low PC bits carry no information
  assign w_unused = ^{f_pc[1:0], e_pc[1:0]};

  assign w_fIdx = f_pc[IDX+1:2];
  assign w_fTag = f_pc[XLEN-1:IDX+2];
  assign w_eIdx = e_pc[IDX+1:2];
  assign w_eTag = e_pc[XLEN-1:IDX+2];

  // Fetch lookup reads registered state only, so an update in flight this
  // cycle is not visible until the next one
  always_comb begin
    f_pred_taken  = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag) && r_cnt[w_fIdx][1];
    f_pred_target = r_target[w_fIdx];
  end

  assign w_eHit       = r_valid[w_eIdx] && (r_tag[w_eIdx] == w_eTag);
  assign e_mispredict = e_valid && (e_taken != e_pred_taken);

  cpu_sat_counter2 u_satCounter (
    .cnt  (r_cnt[w_eIdx]),
    .inc  (e_taken),
    .next (w_cntNext)
  );

  // Valid bits and counters: reset wins over training; a miss allocates only
  // when the branch was actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
      end
    end else if (e_valid) begin
      if (w_eHit) begin
        r_cnt[w_eIdx] <= w_cntNext;
      end else if (e_taken) begin
        r_valid[w_eIdx] <= 1'b1;
        r_cnt[w_eIdx]   <= CNT_WT;
      end
    end
  end

  // Tags and targets are never reset; they are only meaningful behind a
  // valid bit. A taken branch refreshes the target on hit or allocation.
  always_ff @(posedge clk) begin
    if (!rst && e_valid && e_taken) begin
      r_target[w_eIdx] <= e_target;
      if (!w_eHit) r_tag[w_eIdx] <= w_eTag;
    end
  end

  // Statistics counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else if (e_valid) begin
      if (r_branchCount != STAT_MAX) r_branchCount <= r_branchCount + 32'd1;
      if (e_mispredict && (r_mispredictCount != STAT_MAX))
        r_mispredictCount <= r_mispredictCount + 32'd1;
    end
  end

  assign branch_count     = r_branchCount;
  assign mispredict_count = r_mispredictCount;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_cpu_branch_predictor
// Directed scenarios plus randomized traffic against a table model built
// from the prediction rules with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_cpu_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int XLEN    = 32;
  localparam int IDX     = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic [XLEN-1:0] f_pred_target;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic            e_taken;
  logic [XLEN-1:0] e_target;
  logic            e_pred_taken;
  logic            e_mispredict;
  logic [31:0]     mispredict_count;
  logic [31:0]     branch_count;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: one slot per index, counter kept as an integer 0..3
  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCnt    [ENTRIES];
  longint      mBranches;
  longint      mMispredicts;

  cpu_branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .f_pc             (f_pc),
    .f_pred_taken     (f_pred_taken),
    .f_pred_target    (f_pred_target),
    .e_valid          (e_valid),
    .e_pc             (e_pc),
    .e_taken          (e_taken),
    .e_target         (e_target),
    .e_pred_taken     (e_pred_taken),
    .e_mispredict     (e_mispredict),
    .mispredict_count (mispredict_count),
    .branch_count     (branch_count)
  );

  always #5 clk = ~clk;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic bit modelPred(input logic [31:0] pc);
    int s;
    s = slotOf(pc);
    return mValid[s] && (mTag[s] == tagOf(pc)) && (mCnt[s] >= 2);
  endfunction

  // Advance one clock, applying the inputs present at the edge to the model
  task automatic tick();
    int s;
    @(posedge clk);
    s = slotOf(e_pc);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mValid[i] = 1'b0;
        mCnt[i]   = 1;
      end
      mBranches    = 0;
      mMispredicts = 0;
    end else if (e_valid) begin
      mBranches++;
      if (e_taken != e_pred_taken) mMispredicts++;
      if (mValid[s] && mTag[s] == tagOf(e_pc)) begin
        if (e_taken) begin
          mCnt[s]    = (mCnt[s] < 3) ? mCnt[s] + 1 : 3;
          mTarget[s] = e_target;
        end else begin
          mCnt[s] = (mCnt[s] > 0) ? mCnt[s] - 1 : 0;
        end
      end else if (e_taken) begin
        mValid[s]  = 1'b1;
        mTag[s]    = tagOf(e_pc);
        mTarget[s] = e_target;
        mCnt[s]    = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit taken,
                         input logic [31:0] target, input bit predTaken);
    e_valid      = 1'b1;
    e_pc         = pc;
    e_taken      = taken;
    e_target     = target;
    e_pred_taken = predTaken;
  endtask

  task automatic idle();
    e_valid      = 1'b0;
    e_taken      = 1'b0;
    e_pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    f_pc = 32'h100;
    tick();
    tick();
    rst = 1'b0;
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pred: got %b expected 0", f_pred_taken);
    end
    testsRun++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_counts: got br=%0d mp=%0d expected 0/0", branch_count, mispredict_count);
    end
  endtask

  task automatic test_first_taken();
    resolve(32'h100, 1'b1, 32'h40, 1'b0);
    #1;
    testsRun++;
    if (e_mispredict !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL first_mispredict: got %b expected 1", e_mispredict);
    end
    tick();
    idle();
    f_pc = 32'h100;
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h40) begin
      testsFailed++;
      $display("[TB] FAIL first_alloc: got taken=%b target=%h expected 1/00000040", f_pred_taken, f_pred_target);
    end
    testsRun++;
    if (mispredict_count !== 32'd1 || branch_count !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL first_counts: got mp=%0d br=%0d expected 1/1", mispredict_count, branch_count);
    end
  endtask

  // Counter walks 10 -> 01 -> 00 -> 00, then back up 01 -> 10
  task automatic test_not_taken_decay();
    bit exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit tkn [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit prd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    f_pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      resolve(32'h100, tkn[i], 32'h40, prd[i]);
      tick();
      idle();
      #1;
      testsRun++;
      if (f_pred_taken !== exp[i]) begin
        testsFailed++;
        $display("[TB] FAIL decay_step%0d: got %b expected %b", i, f_pred_taken, exp[i]);
      end
    end
    testsRun++;
    if (branch_count !== 32'd6 || mispredict_count !== 32'd4) begin
      testsFailed++;
      $display("[TB] FAIL decay_counts: got br=%0d mp=%0d expected 6/4", branch_count, mispredict_count);
    end
  endtask

  task automatic test_alias();
    resolve(32'h140, 1'b1, 32'h80, 1'b0);
    tick();
    idle();
    f_pc = 32'h100;
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL alias_evicted: got %b expected 0", f_pred_taken);
    end
    f_pc = 32'h140;
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h80) begin
      testsFailed++;
      $display("[TB] FAIL alias_new: got taken=%b target=%h expected 1/00000080", f_pred_taken, f_pred_target);
    end
  endtask

  task automatic test_same_cycle();
    f_pc = 32'h140;
    resolve(32'h140, 1'b0, 32'h0, 1'b1);
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b1 || e_mispredict !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL same_cycle_old: got taken=%b misp=%b expected 1/1", f_pred_taken, e_mispredict);
    end
    tick();
    idle();
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL same_cycle_new: got %b expected 0", f_pred_taken);
    end
  endtask

  task automatic test_reset_priority();
    // Re-arm 0x140 so there is something for reset to clear
    resolve(32'h140, 1'b1, 32'h80, 1'b0);
    tick();
    rst = 1'b1;
    resolve(32'h180, 1'b1, 32'h20, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < ENTRIES; i++) begin
      f_pc = 32'h180 + 32'(i * 4);
      #1;
      testsRun++;
      if (f_pred_taken !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL rst_prio_pred pc=%h: got %b expected 0", f_pc, f_pred_taken);
      end
    end
    f_pc = 32'h140;
    #1;
    testsRun++;
    if (f_pred_taken !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL rst_prio_state: got taken=%b br=%0d mp=%0d expected 0/0/0", f_pred_taken, branch_count, mispredict_count);
    end
  endtask

  // Small PC pool: 4 indices x 4 tags forces hits, misses and aliasing
  task automatic test_random();
    logic [31:0] pc;
    bit          expTaken;
    for (int n = 0; n < 300; n++) begin
      pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      f_pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) != 0)
        resolve(pc, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      else
        idle();
      #1;
      expTaken = modelPred(f_pc);
      testsRun++;
      if (f_pred_taken !== expTaken || (expTaken && f_pred_target !== mTarget[slotOf(f_pc)])) begin
        testsFailed++;
        $display("[TB] FAIL rand_pred pc=%h: got taken=%b target=%h expected %b/%h", f_pc, f_pred_taken, f_pred_target, expTaken, mTarget[slotOf(f_pc)]);
      end
      testsRun++;
      if (e_mispredict !== (e_valid && (e_taken != e_pred_taken))) begin
        testsFailed++;
        $display("[TB] FAIL rand_misp: got %b expected %b", e_mispredict, e_valid && (e_taken != e_pred_taken));
      end
      tick();
      testsRun++;
      if (branch_count !== 32'(mBranches) || mispredict_count !== 32'(mMispredicts)) begin
        testsFailed++;
        $display("[TB] FAIL rand_counts: got br=%0d mp=%0d expected %0d/%0d", branch_count, mispredict_count, mBranches, mMispredicts);
      end
    end
    idle();
  endtask

  initial begin
    rst          = 1'b1;
    f_pc         = '0;
    e_valid      = 1'b0;
    e_pc         = '0;
    e_taken      = 1'b0;
    e_target     = '0;
    e_pred_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_taken();
    test_not_taken_decay();
    test_alias();
    test_same_cycle();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_branch_predictor.md
CPU_BRANCH_PREDICTOR -- requirements
Module: cpu_branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, meaning: number of direct-mapped predictor entries; SHALL be a power of two, 4..256.
REQ-002 Parameter XLEN, default 32, meaning: address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 f_pc  input  XLEN  fetch-stage PC to predict.
REQ-006 f_pred_taken  output  1  prediction "taken" for f_pc; drives branch_pred_taken down the pipe.
REQ-007 f_pred_target  output  XLEN  predicted target for f_pc; don't-care when f_pred_taken=0.
REQ-008 e_valid  input  1  execute stage holds a resolved conditional branch this cycle.
REQ-009 e_pc  input  XLEN  PC of the resolved branch.
REQ-010 e_taken  input  1  actual outcome (branch_cond_val).
REQ-011 e_target  input  XLEN  actual taken target (PC_TARGET).
REQ-012 e_pred_taken  input  1  prediction carried down the pipe with this branch.
REQ-013 e_mispredict  output  1  e_valid && (e_taken != e_pred_taken), combinational.
REQ-014 mispredict_count  output  32  saturating count of mispredicted branches.
REQ-015 branch_count  output  32  saturating count of resolved branches.

Function
REQ-016 Index = pc[IDX+1:2], IDX = log2(ENTRIES); tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
REQ-017 Entry state: valid bit, tag, XLEN-bit target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-018 Lookup combinational, zero latency: f_pred_taken = valid && tag match && counter[1]; f_pred_target = stored target.
REQ-019 On e_valid, entry hit (valid, tag match): counter +1 if e_taken (saturate at 11), -1 if not (saturate at 00); target overwritten with e_target when e_taken.
REQ-020 On e_valid, miss, e_taken=1: allocate/replace entry: valid=1, tag, target=e_target, counter=10 (WT).
REQ-021 On e_valid, miss, e_taken=0: no table change.
REQ-022 Updates take effect next cycle; same-cycle lookup of the entry being updated returns the pre-update value (no bypass).
REQ-023 e_valid=0: table and counters unchanged.
REQ-024 branch_count increments on every e_valid; mispredict_count increments when e_mispredict; both hold at 32'hFFFF_FFFF.
REQ-025 Predictor never affects correctness; only cpu_branch_logic redirect cost.

Reset
REQ-026 While rst=1 at a clock edge: all valid bits 0, all counters 01, both count outputs 0; targets/tags need not reset.
REQ-027 rst has priority over a simultaneous e_valid update; that update is lost.
REQ-028 Cycle after reset deasserts: f_pred_taken=0 for every f_pc.

Structure
REQ-029 Counter encodings and ENTRIES default SHALL live in shared header cpu_branch_pred.vh alongside existing cpu_control.vh constants.
REQ-030 Saturating 2-bit counter next-state SHALL be one sub-module, cpu_sat_counter2 (inputs cnt, inc; output next).
REQ-031 Table as flat register arrays; one write port (execute), one read port (fetch).

Verification
REQ-032 After reset, f_pc=0x100 -> f_pred_taken=0; counts 0.
REQ-033 e_valid, e_pc=0x100, e_taken=1, e_target=0x40, e_pred_taken=0 -> e_mispredict=1; next cycle f_pc=0x100 gives taken, target 0x40; mispredict_count=1, branch_count=1.
REQ-034 Same branch resolved not-taken twice -> counter 10->01->00; f_pred_taken=0 after first; third not-taken keeps 00.
REQ-035 Aliasing: 0x100 allocated, then 0x140 (ENTRIES=16, same index) taken to 0x80 -> 0x100 now predicts not-taken, 0x140 predicts taken to 0x80.
REQ-036 e_valid with update of index of f_pc in same cycle -> f_pred_taken shows old value that cycle, new value next.
REQ-037 rst asserted same cycle as taken e_valid -> next cycle all predictions 0, counts 0.
